// File: rtl/serial_denorm8.sv
// serial_denorm8 -- bit-serial right shifter used to denormalize an 8-bit
// mantissa. It shifts one bit per clock and collects a sticky bit from every
// 1 shifted out of the LSB. Shift counts above 8 saturate to 8.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, taken on an edge only while ready=1
//   m_in    operand, sampled at the accepting edge
//   sh_in   right-shift count 0..15, sampled at the accepting edge
//   ready   high in IDLE and DONE (a start is accepted on the next edge)
//   done    one-cycle pulse, high while in DONE
//   m_out   shifted result (the working data register)
//   sticky  OR of every bit shifted out (the working sticky register)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | one right shift per edge; count reaches zero on the last one
// DONE  | result valid, done=1; a start here begins the next operation
module serial_denorm8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] m_in,
  input  logic [3:0] sh_in,
  output logic       ready,
  output logic       done,
  output logic [7:0] m_out,
  output logic       sticky
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] data_r;
  logic [3:0] cnt_r;
  logic       sticky_r;
  logic [3:0] sh_sat;
  logic       accept;

  // Beyond 8 shifts every operand bit is already gone, so 8 is enough.
  assign sh_sat = (sh_in > 4'd8) ? 4'd8 : sh_in;
  assign accept = start && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (sh_sat == 4'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        ready = 1'b0;
        // <= rather than == so a corrupted zero count cannot hang the FSM.
        if (cnt_r <= 4'd1) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = (sh_sat == 4'd0) ? DONE : SHIFT;
        else        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= 8'h00;
      cnt_r    <= 4'd0;
      sticky_r <= 1'b0;
    end else if (accept) begin
      data_r   <= m_in;
      cnt_r    <= sh_sat;
      sticky_r <= 1'b0;
    end else if (state == SHIFT) begin
      data_r   <= {1'b0, data_r[7:1]};
      cnt_r    <= cnt_r - 4'd1;
      sticky_r <= sticky_r | data_r[0];
    end
  end

  assign m_out  = data_r;
  assign sticky = sticky_r;

endmodule
